// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// frame state encoding, default baud divisor and the parity helper.
package uart_pkg;

  // Clocks per bit for 115200 baud from a 100 MHz clock.
  localparam int CLK_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sender_fifo.sv
// Byte FIFO for the UART transmitter. First-word-fall-through: rdata always
// shows the head entry, so the consumer can load and pop in the same cycle.
// Pushes while full and pops while empty are ignored.
module sender_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] wdata,
  input  logic       we,
  output logic       full,
  output logic [7:0] rdata,
  input  logic       re,
  output logic       empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  push_s;
  logic                  pop_s;

  assign full   = (count_r == COUNT_FULL);
  assign empty  = (count_r == '0);
  assign push_s = we && !full;
  assign pop_s  = re && !empty;
  assign rdata  = mem_r[rd_ptr_r];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at 2**DEPTH_LOG2; count tracks occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_r <= count_r - (DEPTH_LOG2 + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/buffered_sender.sv
// UART transmitter with an input byte FIFO. The core enqueues bytes with a
// valid/ready handshake and is stalled only while the FIFO is full.
// Frames are 8N1 by default; defining BUFFERED_SENDER_PARITY_EN adds an even
// parity bit between the data and stop bits (8E1).
// Back-to-back queued bytes are sent with no idle gap between frames.
module buffered_sender
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT     = CLK_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       idle
);

  localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

  uart_state_e       state_r, state_s;
  logic [BAUD_W-1:0] baud_r, baud_s;
  logic [2:0]        idx_r, idx_s;
  logic [7:0]        shift_r, shift_s;
  logic              tx_r, tx_s;
`ifdef BUFFERED_SENDER_PARITY_EN
  logic              parity_r, parity_s;
`endif

  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic [7:0] fifo_rdata_s;
  logic       bit_end_s;
  logic       pop_s;

  sender_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .wdata (data),
    .we    (valid),
    .full  (fifo_full_s),
    .rdata (fifo_rdata_s),
    .re    (pop_s),
    .empty (fifo_empty_s)
  );

  assign bit_end_s = (baud_r == BAUD_LAST);
  // A byte leaves the FIFO when a new frame starts: from IDLE, or straight
  // out of the last stop-bit cycle so consecutive frames abut.
  assign pop_s = !fifo_empty_s &&
                 ((state_r == IDLE) || ((state_r == STOP) && bit_end_s));

  assign ready = !fifo_full_s;
  assign tx    = tx_r;
  assign idle  = (state_r == IDLE) && fifo_empty_s;

  // Next-state logic for the frame sequencer, baud counter and shifter.
  always_comb begin
    state_s  = state_r;
    baud_s   = baud_r + BAUD_W'(1);
    idx_s    = idx_r;
    shift_s  = shift_r;
    tx_s     = tx_r;
`ifdef BUFFERED_SENDER_PARITY_EN
    parity_s = parity_r;
`endif
    case (state_r)
      IDLE: begin
        baud_s = '0;
        if (!fifo_empty_s) begin
          state_s  = START;
          shift_s  = fifo_rdata_s;
`ifdef BUFFERED_SENDER_PARITY_EN
          parity_s = even_parity(fifo_rdata_s);
`endif
          tx_s     = 1'b0;
        end else begin
          tx_s = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          baud_s  = '0;
          idx_s   = 3'd0;
          tx_s    = shift_r[0];
        end else begin
          tx_s = 1'b0;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_s = '0;
          if (idx_r == 3'd7) begin
`ifdef BUFFERED_SENDER_PARITY_EN
            state_s = PARITY;
            tx_s    = parity_r;
`else
            state_s = STOP;
            tx_s    = 1'b1;
`endif
          end else begin
            idx_s   = idx_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
            tx_s    = shift_r[1];
          end
        end else begin
          tx_s = shift_r[0];
        end
      end
`ifdef BUFFERED_SENDER_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
          baud_s  = '0;
          tx_s    = 1'b1;
        end else begin
          tx_s = parity_r;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          baud_s = '0;
          if (!fifo_empty_s) begin
            state_s  = START;
            shift_s  = fifo_rdata_s;
`ifdef BUFFERED_SENDER_PARITY_EN
            parity_s = even_parity(fifo_rdata_s);
`endif
            tx_s     = 1'b0;
          end else begin
            state_s = IDLE;
            tx_s    = 1'b1;
          end
        end else begin
          tx_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = '0;
        tx_s    = 1'b1;
      end
    endcase
  end

  // Sequencer state; reset drops any frame in progress and idles the line.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= IDLE;
      baud_r   <= '0;
      idx_r    <= 3'd0;
      shift_r  <= 8'h00;
      tx_r     <= 1'b1;
`ifdef BUFFERED_SENDER_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      baud_r   <= baud_s;
      idx_r    <= idx_s;
      shift_r  <= shift_s;
      tx_r     <= tx_s;
`ifdef BUFFERED_SENDER_PARITY_EN
      parity_r <= parity_s;
`endif
    end
  end

endmodule
